exe_muldiv_unit: RTL and testbench
==================================

// Module: exe_muldiv_unit
// PURPOSE
//   Multiply/divide unit of the Execute stage, directly upstream of the Memory stage.
//   Owns the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU as multi-cycle
//   operations with a busy counter. Also performs the MTHI/MTLO writes.
//   Exports md_stall so the Decode-stage hazard logic freezes any MD instruction or
//   MFHI/MFLO while an operation is in flight.
//   HI/LO read values travel down the pipeline with alu_res into Memory.
// PARAMETERS
//   MULT_LAT  5   cycles busy is high for MULT/MULTU (>=1)
//   DIV_LAT   10  cycles busy is high for DIV/DIVU (>=1)
// PORTS
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous, active-low reset
//   md_start  in   1   E-stage instruction is an MD op; qualifies md_op
//   md_op     in   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others NONE
//   md_a      in   32  rs operand, already forwarded
//   md_b      in   32  rt operand, already forwarded
//   md_busy   out  1   operation in flight
//   md_stall  out  1   md_busy | (md_start & op in 1..4); combinational
//   md_done   out  1   one-cycle pulse in the first cycle the new HI/LO are visible
//   hi        out  32  HI register
//   lo        out  32  LO register
// BEHAVIOUR
// - Reset (reset=0, asynchronous)
//   - Clears hi, lo, md_busy, md_done, the counter and the operand latches immediately.
//   - An in-flight operation is discarded and never commits.
// - Idle accept (md_busy=0, md_start=1, md_op in 1..4)
//   - At the accept edge: latch md_a, md_b and md_op.
//   - Load the counter with MULT_LAT or DIV_LAT; md_busy goes to 1.
// - In flight
//   - The counter decrements every edge.
//   - At the edge where counter==1: commit hi/lo, md_busy goes to 0, md_done goes to 1
//     for exactly one cycle.
//   - md_busy is therefore high for exactly LAT cycles after the accept edge.
//   - hi/lo keep their old values until the commit edge.
// - md_start while md_busy=1
//   - Ignored. No operand latch, no restart, no MTHI/MTLO write.
//   - Upstream must hold the instruction via md_stall.
// - MTHI/MTLO (md_busy=0)
//   - hi, or lo, <= md_a at the next edge.
//   - md_busy and md_done stay at 0.
// - Arithmetic
//   - MULT: {hi,lo} = signed 64-bit product.
//   - MULTU: {hi,lo} = unsigned 64-bit product.
//   - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//   - DIVU: unsigned quotient in lo, unsigned remainder in hi.
//   - Divide by zero (DIV or DIVU): the operation still occupies DIV_LAT cycles and pulses
//     md_done, but hi and lo are left unchanged.
//   - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, with no trap.
// - Results are computed only from the latched operands. Operand inputs that change
//   during busy have no effect.
// - md_op NONE or undefined with md_start=1: no state change.
// - Back-to-back: a new op may be accepted in the same cycle md_done=1.
//   - md_busy=0 in that cycle, so md_stall = md_start & op in 1..4 only.
//   - At that cycle's edge the new op is accepted and the counter reloads.
// TESTING
// - Reset, then MULT a=3 b=0xFFFFFFFE -> busy high 5 cycles; then hi=0xFFFFFFFF
//   lo=0xFFFFFFFA and done pulses once.
// - MULTU a=0xFFFFFFFF b=2 -> after 5 cycles hi=0x00000001 lo=0xFFFFFFFE.
// - DIV a=-7 (0xFFFFFFF9) b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD hi=0xFFFFFFFF.
//   DIVU a=7 b=0 -> hi/lo unchanged, done still pulses after 10 cycles.
// - MULT accepted, then MTLO and a second MULT issued while busy -> both ignored;
//   md_stall=1 throughout; only the first result commits.
// - Drive reset low 2 cycles into a DIV -> hi=lo=0 and busy=0 at once; no later commit.
//   MTHI a=0x12345678 when idle -> hi=0x12345678 next cycle, busy stays 0.
// - Issue a new MULT in the md_done cycle -> accepted that edge; busy high 5 more cycles.

Source files
------------

// File: rtl/exe_muldiv_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU over a
// fixed busy window and handles MTHI/MTLO writes.
module exe_muldiv_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    output logic        md_busy,
    output logic        md_stall,
    output logic        md_done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } md_op_e;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [31:0]   a_q, b_q;

    logic          is_long, is_mul;
    logic [63:0]   prod;
    logic          div_sgn, q_neg;
    logic [31:0]   ua, ub, ub_safe, uq, ur;
    logic [31:0]   res_hi, res_lo;
    logic          res_wr;

    assign is_long  = (md_op >= 4'd1) && (md_op <= 4'd4);
    assign is_mul   = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign md_stall = md_busy | (md_start & is_long);

    // Results come only from the latched operands so inputs may wander while busy.
    always_comb begin
        prod    = '0;
        div_sgn = (op_q == OP_DIV);
        ua      = (div_sgn && a_q[31]) ? -a_q : a_q;
        ub      = (div_sgn && b_q[31]) ? -b_q : b_q;
        ub_safe = (ub == 32'd0) ? 32'd1 : ub;
        uq      = ua / ub_safe;
        ur      = ua % ub_safe;
        q_neg   = div_sgn && (a_q[31] ^ b_q[31]);
        res_hi  = '0;
        res_lo  = '0;
        res_wr  = 1'b0;
        case (op_q)
            OP_MULT: begin
                prod   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                prod   = {32'd0, a_q} * {32'd0, b_q};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_wr = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                // Magnitude division then sign fix-up; 0x80000000 / -1 wraps to 0x80000000.
                res_lo = q_neg ? -uq : uq;
                res_hi = (div_sgn && a_q[31]) ? -ur : ur;
                res_wr = (b_q != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi      <= '0;
            lo      <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
            cnt     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            md_done <= 1'b0;
            if (md_busy) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    md_busy <= 1'b0;
                    md_done <= 1'b1;
                    if (res_wr) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
            end else if (md_start) begin
                if (is_long) begin
                    op_q    <= md_op;
                    a_q     <= md_a;
                    b_q     <= md_b;
                    md_busy <= 1'b1;
                    cnt     <= is_mul ? CW'(MULT_LAT) : CW'(DIV_LAT);
                end else if (md_op == OP_MTHI) begin
                    hi <= md_a;
                end else if (md_op == OP_MTLO) begin
                    lo <= md_a;
                end
            end
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: latencies, arithmetic, busy-ignore, reset abort,
// MTHI and back-to-back issue.
module tb_exe_muldiv_unit;

    logic        clk, reset, md_start;
    logic [3:0]  md_op;
    logic [31:0] md_a, md_b;
    logic        md_busy, md_stall, md_done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    exe_muldiv_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
        .md_a(md_a), .md_b(md_b), .md_busy(md_busy), .md_stall(md_stall),
        .md_done(md_done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one accept edge, then drop md_start.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start = 1'b1; md_op = op; md_a = a; md_b = b;
        tick();
        md_start = 1'b0; md_op = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0; md_start = 1'b0; md_op = 4'd0; md_a = '0; md_b = '0;
        tick(); tick();
        tests++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++;
            $display("FAIL reset_state got busy=%0b done=%0b hi=%h lo=%h want 0 0 0 0", md_busy, md_done, hi, lo);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        md_start = 1'b1; md_op = 4'd1; md_a = 32'd3; md_b = 32'hFFFFFFFE;
        #1;
        tests++;
        if (md_stall !== 1'b1) begin fails++; $display("FAIL mult_stall_idle got %0b want 1", md_stall); end
        tick();
        md_start = 1'b0; md_op = 4'd0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (md_busy !== 1'b1 || md_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                fails++;
                $display("FAIL mult_busy cyc%0d got busy=%0b done=%0b hi=%h lo=%h want 1 0 0 0", i, md_busy, md_done, hi, lo);
            end
            tick();
        end
        tests++;
        if (md_busy !== 1'b0 || md_done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            fails++;
            $display("FAIL mult_result got busy=%0b done=%0b hi=%h lo=%h want 0 1 ffffffff fffffffa", md_busy, md_done, hi, lo);
        end
        tick();
        tests++;
        if (md_done !== 1'b0) begin fails++; $display("FAIL mult_done_once got %0b want 0", md_done); end
    endtask

    task automatic test_multu();
        issue(4'd2, 32'hFFFFFFFF, 32'd2);
        repeat (5) tick();
        tests++;
        if (md_done !== 1'b1 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
            fails++;
            $display("FAIL multu_result got done=%0b hi=%h lo=%h want 1 00000001 fffffffe", md_done, hi, lo);
        end
        tick();
    endtask

    task automatic test_div();
        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (md_busy !== 1'b1 || md_done !== 1'b0) begin
                fails++;
                $display("FAIL div_busy cyc%0d got busy=%0b done=%0b want 1 0", i, md_busy, md_done);
            end
            tick();
        end
        tests++;
        if (md_done !== 1'b1 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL div_result got done=%0b hi=%h lo=%h want 1 ffffffff fffffffd", md_done, hi, lo);
        end
        tick();
        // Divide by zero keeps HI/LO from the DIV above but still pulses done.
        issue(4'd4, 32'd7, 32'd0);
        repeat (10) tick();
        tests++;
        if (md_done !== 1'b1 || md_busy !== 1'b0 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL divu_by_zero got done=%0b busy=%0b hi=%h lo=%h want 1 0 ffffffff fffffffd", md_done, md_busy, hi, lo);
        end
        tick();
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        repeat (10) tick();
        tests++;
        if (lo !== 32'h80000000 || hi !== 32'd0) begin
            fails++;
            $display("FAIL div_overflow got hi=%h lo=%h want 00000000 80000000", hi, lo);
        end
        tick();
        issue(4'd4, 32'd100, 32'd7);
        repeat (10) tick();
        tests++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            fails++;
            $display("FAIL divu_result got hi=%h lo=%h want 00000002 0000000e", hi, lo);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        logic [31:0] lo_before;
        issue(4'd1, 32'd2, 32'd3);
        lo_before = lo;
        md_start = 1'b1; md_op = 4'd6; md_a = 32'hDEADBEEF;
        #1;
        tests++;
        if (md_stall !== 1'b1) begin fails++; $display("FAIL ign_stall_mtlo got %0b want 1", md_stall); end
        tick();
        tests++;
        if (lo !== lo_before) begin fails++; $display("FAIL ign_mtlo got lo=%h want %h", lo, lo_before); end
        md_op = 4'd1; md_a = 32'd5; md_b = 32'd5;
        #1;
        tests++;
        if (md_stall !== 1'b1) begin fails++; $display("FAIL ign_stall_mult got %0b want 1", md_stall); end
        tick(); tick();
        tests++;
        if (md_stall !== 1'b1 || md_busy !== 1'b1) begin
            fails++;
            $display("FAIL ign_busy got stall=%0b busy=%0b want 1 1", md_stall, md_busy);
        end
        md_start = 1'b0; md_op = 4'd0;
        tick(); tick();
        tests++;
        if (md_done !== 1'b1 || hi !== 32'd0 || lo !== 32'd6) begin
            fails++;
            $display("FAIL ign_result got done=%0b hi=%h lo=%h want 1 00000000 00000006", md_done, hi, lo);
        end
        tick();
        tests++;
        if (md_busy !== 1'b0 || lo !== 32'd6) begin
            fails++;
            $display("FAIL ign_no_restart got busy=%0b lo=%h want 0 00000006", md_busy, lo);
        end
    endtask

    task automatic test_reset_abort();
        issue(4'd3, 32'd100, 32'd7);
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (hi !== 32'd0 || lo !== 32'd0 || md_busy !== 1'b0 || md_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_async got busy=%0b done=%0b hi=%h lo=%h want 0 0 0 0", md_busy, md_done, hi, lo);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            tests++;
            if (md_busy !== 1'b0 || md_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                fails++;
                $display("FAIL abort_no_commit cyc%0d got busy=%0b done=%0b hi=%h lo=%h want 0 0 0 0", i, md_busy, md_done, hi, lo);
            end
        end
        md_start = 1'b1; md_op = 4'd5; md_a = 32'h12345678;
        #1;
        tests++;
        if (md_stall !== 1'b0) begin fails++; $display("FAIL mthi_stall got %0b want 0", md_stall); end
        tick();
        md_start = 1'b0; md_op = 4'd0;
        tests++;
        if (hi !== 32'h12345678 || lo !== 32'd0 || md_busy !== 1'b0 || md_done !== 1'b0) begin
            fails++;
            $display("FAIL mthi_write got hi=%h lo=%h busy=%0b done=%0b want 12345678 0 0 0", hi, lo, md_busy, md_done);
        end
        tick();
        tests++;
        if (md_busy !== 1'b0 || md_done !== 1'b0) begin
            fails++;
            $display("FAIL mthi_quiet got busy=%0b done=%0b want 0 0", md_busy, md_done);
        end
        // Undefined op with md_start does nothing.
        issue(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tests++;
        if (hi !== 32'h12345678 || lo !== 32'd0 || md_busy !== 1'b0) begin
            fails++;
            $display("FAIL undef_op got hi=%h lo=%h busy=%0b want 12345678 0 0", hi, lo, md_busy);
        end
    endtask

    task automatic test_back_to_back();
        int waited = 0;
        issue(4'd1, 32'd4, 32'd5);
        while (md_done !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        tests++;
        if (md_done !== 1'b1 || lo !== 32'd20) begin
            fails++;
            $display("FAIL b2b_first got done=%0b lo=%h after %0d cycles want 1 00000014", md_done, lo, waited);
        end
        md_start = 1'b1; md_op = 4'd1; md_a = 32'd6; md_b = 32'd7;
        #1;
        tests++;
        if (md_busy !== 1'b0 || md_stall !== 1'b1) begin
            fails++;
            $display("FAIL b2b_stall got busy=%0b stall=%0b want 0 1", md_busy, md_stall);
        end
        tick();
        md_start = 1'b0; md_op = 4'd0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (md_busy !== 1'b1 || md_done !== 1'b0 || lo !== 32'd20) begin
                fails++;
                $display("FAIL b2b_busy cyc%0d got busy=%0b done=%0b lo=%h want 1 0 00000014", i, md_busy, md_done, lo);
            end
            tick();
        end
        tests++;
        if (md_done !== 1'b1 || hi !== 32'd0 || lo !== 32'd42) begin
            fails++;
            $display("FAIL b2b_second got done=%0b hi=%h lo=%h want 1 00000000 0000002a", md_done, hi, lo);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
